vector_op_controller: RTL and testbench

VECTOR_OP_CONTROLLER -- requirements
Module: vector_op_controller

---
 rtl/vector_op_controller_pkg.sv | 29 ++
 rtl/vector_op_controller_if.sv | 38 +++
 rtl/vector_op_controller_lane_alu.sv | 51 +++++
 rtl/vector_op_controller.sv | 112 +++++++++++
 tb/tb_vector_op_controller.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_op_controller_pkg.sv
// vector_op_controller_pkg
// Shared definitions for the vector operation controller slice:
//   - default lane geometry (16 lanes x 32 bits = one 512-bit vector)
//   - opcode encodings presented on the opcode port
//   - FSM state encoding used by the controller
// No ports; imported by the interface, the lane ALU and the top.
package vector_op_controller_pkg;

  localparam int LANES_DEF  = 16;
  localparam int LANE_W_DEF = 32;
  localparam int VEC_W      = 512;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_SUB  = 2'b10,
    OP_COPY = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/vector_op_controller_if.sv
// vector_op_controller_if
// Bundles the request handshake and the register-file bus of the
// vector operation controller.
//   start, opcode            : operation request (requester -> controller)
//   busy, done               : status (controller -> requester)
//   rf_read_two              : dual-read strobe for regs 0/1
//   rf_data_out_1/2          : operands A/B returned by the register file
//   rf_write_two             : dual-write strobe for regs 2/3
//   rf_data_in_1/2           : result low/high words toward the register file
// Modports: master = requester/register-file side, slave = controller.
interface vector_op_controller_if
  import vector_op_controller_pkg::*;
#(
  parameter int W = VEC_W
);

  logic         start;
  logic [1:0]   opcode;
  logic         busy;
  logic         done;
  logic         rf_read_two;
  logic [W-1:0] rf_data_out_1;
  logic [W-1:0] rf_data_out_2;
  logic         rf_write_two;
  logic [W-1:0] rf_data_in_1;
  logic [W-1:0] rf_data_in_2;

  modport master (
    output start, opcode, rf_data_out_1, rf_data_out_2,
    input  busy, done, rf_read_two, rf_write_two, rf_data_in_1, rf_data_in_2
  );

  modport slave (
    input  start, opcode, rf_data_out_1, rf_data_out_2,
    output busy, done, rf_read_two, rf_write_two, rf_data_in_1, rf_data_in_2
  );

endinterface

// File: rtl/vector_op_controller_lane_alu.sv
// lane_alu
// Purely combinational single-lane arithmetic unit.
//   opcode_i : operation (add, mul, sub, copy)
//   a_i, b_i : unsigned lane operands
//   lo_o     : low result word (sum, low product, difference, or A)
//   hi_o     : high result word (carry, high product, borrow mask, or B)
module lane_alu
  import vector_op_controller_pkg::*;
#(
  parameter int W = LANE_W_DEF
) (
  input  opcode_e        opcode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   lo_o,
  output logic [W-1:0]   hi_o
);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;

  // One extra bit on sum/diff exposes the carry and the borrow; the
  // borrow bit of an unsigned subtraction is exactly the a<b flag.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    lo_o = '0;
    hi_o = '0;
    unique case (opcode_i)
      OP_ADD: begin
        lo_o = sum[W-1:0];
        hi_o = {{(W-1){1'b0}}, sum[W]};
      end
      OP_MUL: begin
        lo_o = prod[W-1:0];
        hi_o = prod[2*W-1:W];
      end
      OP_SUB: begin
        lo_o = diff[W-1:0];
        hi_o = {W{diff[W]}};
      end
      OP_COPY: begin
        lo_o = a_i;
        hi_o = b_i;
      end
    endcase
  end

endmodule

// File: rtl/vector_op_controller.sv
// vector_op_controller
// Sequences one vector operation over the register file:
// read regs 0/1, capture operands, run the lane ALU across every lane
// (one lane per clock), then write the result pair to regs 2/3.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset, aborts any operation
//   bus  : slave modport of vector_op_controller_if (request handshake,
//          status, register-file read/write strobes and data)
module vector_op_controller
  import vector_op_controller_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_op_controller_if.slave bus
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int V_W   = LANES * LANE_W;

  state_e            state_q, state_d;
  opcode_e           opcode_q;
  logic [CNT_W-1:0]  lane_q;
  logic [V_W-1:0]    a_q, b_q;
  logic [V_W-1:0]    r1_q, r2_q;
  logic [LANE_W-1:0] lane_a, lane_b, lane_lo, lane_hi;
  logic              lane_last;

  assign lane_a    = a_q[lane_q*LANE_W +: LANE_W];
  assign lane_b    = b_q[lane_q*LANE_W +: LANE_W];
  assign lane_last = (lane_q == CNT_W'(LANES - 1));

  lane_alu #(
    .W(LANE_W)
  ) u_lane_alu (
    .opcode_i (opcode_q),
    .a_i      (lane_a),
    .b_i      (lane_b),
    .lo_o     (lane_lo),
    .hi_o     (lane_hi)
  );

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start is only looked at in IDLE, so a request
  // arriving while busy is simply dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = EXEC;
      EXEC:    if (lane_last) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers. Operands are taken at the end of WAIT, one cycle
  // after the read strobe, which is when the register file has them on
  // its outputs. The lane counter is zeroed on the way into EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= OP_ADD;
      lane_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          lane_q <= '0;
          if (bus.start) opcode_q <= opcode_e'(bus.opcode);
        end
        WAIT: begin
          a_q    <= bus.rf_data_out_1;
          b_q    <= bus.rf_data_out_2;
          lane_q <= '0;
        end
        EXEC: begin
          r1_q[lane_q*LANE_W +: LANE_W] <= lane_lo;
          r2_q[lane_q*LANE_W +: LANE_W] <= lane_hi;
          lane_q <= lane_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded from state; read and write strobes live in
  // different states so they can never overlap.
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.rf_read_two  = (state_q == READ);
  assign bus.rf_write_two = (state_q == WRITE);
  assign bus.rf_data_in_1 = r1_q;
  assign bus.rf_data_in_2 = r2_q;

endmodule

// File: tb/tb_vector_op_controller.sv
// tb_vector_op_controller
// Scoreboard bench for vector_op_controller: stimulus pushes the expected
// result pair and completion cycle into a queue, a monitor pops it when
// the DUT strobes rf_write_two and checks done timing.
module tb_vector_op_controller;

  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int VW     = 512;

  typedef struct {
    logic [VW-1:0] lo;
    logic [VW-1:0] hi;
    int            doneCycle;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [VW-1:0] reg0, reg1, reg2, reg3;

  int   total = 0;
  int   bad = 0;
  int   cycleCount = 0;
  int   writeCount = 0;
  int   doneCount = 0;
  int   opsIssued = 0;
  int   pendingDone = 0;
  exp_t expQ[$];

  vector_op_controller_if #(.W(VW)) bus ();

  vector_op_controller #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: regs 0/1 feed the DUT, regs 2/3 capture on negedge.
  assign bus.rf_data_out_1 = reg0;
  assign bus.rf_data_out_2 = reg1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(negedge clk) begin
    if (bus.rf_write_two === 1'b1) begin
      reg2 <= bus.rf_data_in_1;
      reg3 <= bus.rf_data_in_2;
    end
  end

  task automatic checkOutput(input string name, input logic [VW-1:0] act,
                             input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic void modelOp(input logic [1:0] op, input logic [VW-1:0] a,
                                  input logic [VW-1:0] b,
                                  output logic [VW-1:0] lo,
                                  output logic [VW-1:0] hi);
    logic [63:0] x, y, r;
    lo = '0;
    hi = '0;
    for (int i = 0; i < LANES; i++) begin
      x = {32'd0, a[i*LANE_W +: LANE_W]};
      y = {32'd0, b[i*LANE_W +: LANE_W]};
      case (op)
        2'b00: begin r = x + y; lo[i*32 +: 32] = r[31:0]; hi[i*32 +: 32] = r[63:32]; end
        2'b01: begin r = x * y; lo[i*32 +: 32] = r[31:0]; hi[i*32 +: 32] = r[63:32]; end
        2'b10: begin
          r = x - y;
          lo[i*32 +: 32] = r[31:0];
          hi[i*32 +: 32] = (x < y) ? 32'hFFFFFFFF : 32'h0;
        end
        default: begin lo[i*32 +: 32] = x[31:0]; hi[i*32 +: 32] = y[31:0]; end
      endcase
    end
  endfunction

  // Monitor: pops an expectation on every write strobe, checks data and
  // that done follows one cycle later at the predicted cycle.
  always @(negedge clk) begin
    if (cycleCount > 2) begin
      checkOutput("rw_exclusive", VW'(bus.rf_read_two & bus.rf_write_two), '0);
      if (bus.rf_write_two) begin
        writeCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", VW'(bus.rf_write_two), '0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("result_lo", bus.rf_data_in_1, e.lo);
          checkOutput("result_hi", bus.rf_data_in_2, e.hi);
          checkOutput("write_cycle", VW'(cycleCount), VW'(e.doneCycle - 1));
          pendingDone = e.doneCycle;
        end
      end
      if (bus.done) begin
        doneCount++;
        checkOutput("done_cycle", VW'(cycleCount), VW'(pendingDone));
        pendingDone = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [VW-1:0] a,
                               input logic [VW-1:0] b, input bit expectIt,
                               input bit keepStart);
    int   waitCount = 0;
    exp_t e;
    @(negedge clk);
    while (bus.busy && waitCount < 100) begin
      @(negedge clk);
      waitCount++;
    end
    if (bus.busy) checkOutput("idle_timeout", VW'(bus.busy), '0);
    reg0       = a;
    reg1       = b;
    bus.opcode = op;
    bus.start  = 1'b1;
    if (expectIt) begin
      modelOp(op, a, b, e.lo, e.hi);
      e.doneCycle = cycleCount + 20;
      expQ.push_back(e);
      opsIssued++;
    end
    @(negedge clk);
    if (!keepStart) bus.start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || pendingDone != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VW-1:0] va, vb, snap2, snap3, exLo, exHi;
    int            snapWrites;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = 2'b00;
    reg0 = '0; reg1 = '0; reg2 = '0; reg3 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", VW'(bus.busy), '0);
    checkOutput("reset_done", VW'(bus.done), '0);
    checkOutput("reset_read", VW'(bus.rf_read_two), '0);
    checkOutput("reset_write", VW'(bus.rf_write_two), '0);
    checkOutput("reset_r1", bus.rf_data_in_1, '0);
    checkOutput("reset_r2", bus.rf_data_in_2, '0);
    rst = 1'b0;

    // add with carry out of every lane
    applyStimulus(2'b00, {LANES{32'hFFFFFFFF}}, {LANES{32'h1}}, 1'b1, 1'b0);
    waitDrain();
    checkOutput("add_reg2", reg2, '0);
    checkOutput("add_reg3", reg3, {LANES{32'h1}});

    // mul: A lane i = i+1, B = 2^31
    for (int i = 0; i < LANES; i++) begin
      va[i*32 +: 32]   = i + 1;
      vb[i*32 +: 32]   = 32'h80000000;
      exLo[i*32 +: 32] = (i % 2 == 0) ? 32'h80000000 : 32'h0;
      exHi[i*32 +: 32] = (i + 1) / 2;
    end
    applyStimulus(2'b01, va, vb, 1'b1, 1'b0);
    waitDrain();
    checkOutput("mul_reg2", reg2, exLo);
    checkOutput("mul_reg3", reg3, exHi);

    // sub with borrow
    applyStimulus(2'b10, {LANES{32'd5}}, {LANES{32'd7}}, 1'b1, 1'b0);
    waitDrain();
    checkOutput("sub_reg2", reg2, {LANES{32'hFFFFFFFE}});
    checkOutput("sub_reg3", reg3, {LANES{32'hFFFFFFFF}});

    // copy with distinct per-lane patterns
    for (int i = 0; i < LANES; i++) begin
      va[i*32 +: 32] = ($urandom & 32'h0FFFFFFF) | (32'(i) << 28);
      vb[i*32 +: 32] = ($urandom & 32'h0FFFFFFF) | (32'(15 - i) << 28);
    end
    applyStimulus(2'b11, va, vb, 1'b1, 1'b0);
    waitDrain();
    checkOutput("copy_reg2", reg2, reg0);
    checkOutput("copy_reg3", reg3, reg1);

    // start pulsed during EXEC must be dropped
    applyStimulus(2'($urandom_range(0, 3)), randVec(), randVec(), 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDrain();
    repeat (25) @(negedge clk);

    // reset at EXEC lane 7 aborts without a write
    snap2      = reg2;
    snap3      = reg3;
    snapWrites = writeCount;
    applyStimulus(2'b00, randVec(), randVec(), 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", VW'(bus.busy), '0);
    checkOutput("abort_write", VW'(bus.rf_write_two), '0);
    checkOutput("abort_r1", bus.rf_data_in_1, '0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("abort_reg2", reg2, snap2);
    checkOutput("abort_reg3", reg3, snap3);
    checkOutput("abort_writes", VW'(writeCount), VW'(snapWrites));
    applyStimulus(2'($urandom_range(0, 3)), randVec(), randVec(), 1'b1, 1'b0);
    waitDrain();

    // start held across completion launches a second op in the next IDLE
    applyStimulus(2'b01, randVec(), randVec(), 1'b1, 1'b1);
    applyStimulus(2'b10, randVec(), randVec(), 1'b1, 1'b0);
    waitDrain();

    // random operations
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'($urandom_range(0, 3)), randVec(), randVec(), 1'b1, 1'b0);
      waitDrain();
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", VW'(expQ.size()), '0);
    checkOutput("write_total", VW'(writeCount), VW'(opsIssued));
    checkOutput("done_total", VW'(doneCount), VW'(opsIssued));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
